mult_booth_seq: RTL
===================

# mult_booth_seq

Sequential signed 32×32 multiplier for the processor's multdiv unit, the multiply counterpart of the restoring divider. It uses radix-4 modified Booth recoding and retires 2 multiplier bits per cycle, so one multiply takes 16 compute cycles. It returns the low 32 bits of the 64-bit product and an overflow exception. It has an internal iteration counter and a start/ready handshake, so the multdiv wrapper does not supply an external count.

## Interface
Parameters: none (fixed 32-bit datapath).
- `clock` in 1: single clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a multiply; sampled only in IDLE.
- `multiplicand` in 32: signed operand A, sampled on the start edge.
- `multiplier` in 32: signed operand B, sampled on the start edge.
- `busy` out 1: high in RUN and DONE.
- `resultReady` out 1: high for exactly one cycle (DONE).
- `result` out 32: low 32 bits of A×B; held until the next accepted start.
- `exception` out 1: signed overflow flag; valid and held alongside `result`.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE, start=1: latch state.
  - hi[33:0] = 0, lo[31:0] = B, q = 0 (implicit B[-1]).
  - Acand[33:0] = sign-extended A.
  - Counter = 0, go to RUN.
- IDLE, start=0: nothing changes.
- RUN, each cycle:
  - Recode {lo[1:0], q}:
    - 000 or 111 → 0
    - 001 or 010 → +A
    - 011 → +2A
    - 100 → −2A
    - 101 or 110 → −A
  - hi ← hi + recoded term, using a 34-bit adder; −A is ~A + 1 via carry-in.
  - Arithmetic right shift of {hi, lo, q} by 2.
  - Counter increments; after iteration 15, go to DONE.
- DONE:
  - result ← lo.
  - exception ← overflow (see Configuration).
  - resultReady=1 for this cycle, then IDLE.
- `start` in RUN or DONE is ignored; the operands are not re-latched and no request is queued.
- Full product is {hi[31:0], lo}. A 34-bit hi is needed to hold ±2A without losing sign.
- Reset at any time:
  - State IDLE, counter 0.
  - Datapath cleared; result=0, exception=0, busy=0, resultReady=0.
  - An in-flight operation is discarded.

## Timing
- Start accepted at edge E0. RUN iterations occur at edges E1..E16. DONE is the cycle after E16, and result/exception update at E17 together with the return to IDLE.
- resultReady is asserted combinationally from DONE. The wrapper samples result at E17 or any later cycle; result is stable from E17 until the next accepted start's DONE.
- busy rises in the cycle after E0 and falls after E17. Latency from start sample to resultReady is 17 cycles.
- Back-to-back: start may be high in the first IDLE cycle after E17 and is accepted at E18.
- A reset_n low mid-cycle takes effect immediately. After release, the first rising edge is the earliest start sample.

## Configuration
- `MULT_OVF_EN` defined:
  - exception = 1 iff hi[31:0] ≠ {32{lo[31]}}, i.e. the 64-bit product does not fit in signed 32 bits.
- `MULT_OVF_EN` not defined:
  - exception is tied to 0 and the comparison logic is not built.
  - result and timing are identical in both builds.

## Test plan
- 3 × 4, one start pulse: resultReady exactly 17 cycles after the start edge, result=0x0000000C, exception=0, busy high 17 cycles.
- −7 × 6 (0xFFFFFFF9, 0x00000006): result=0xFFFFFFD6, exception=0. Repeat 6 × −7 with the same result.
- 0x80000000 × 0xFFFFFFFF: result=0x80000000, exception=1 with `MULT_OVF_EN`, 0 without. Also 0x00010000 × 0x00010000 → result 0, exception 1 or 0 respectively.
- Start 5 × 5, hold start high and change the operands to 9 × 9 during RUN: result=25, and no second resultReady until start is re-sampled in IDLE.
- Assert reset_n low at cycle 8 of a 0x7FFFFFFF × 2 run: result, exception, busy and resultReady go to 0 immediately. After release, a 2 × 3 start gives result=6 after 17 cycles.
- Random signed operand pairs, back-to-back starts issued on every first-IDLE cycle: result matches the low 32 bits of the reference product, one resultReady per start.

Source files
------------

// File: rtl/mult_booth_seq_if.sv
// mult_booth_seq_if: start/ready handshake and operand/result bus
// for the sequential Booth multiplier.
interface mult_booth_seq_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        resultReady;
  logic [31:0] result;
  logic        exception;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  resultReady,
    input  result,
    input  exception
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output resultReady,
    output result,
    output exception
  );
endinterface

// File: rtl/mult_booth_seq.sv
// mult_booth_seq: radix-4 Booth signed 32x32 multiplier, 16 cycles.
// Define MULT_OVF_EN to build the signed-overflow exception logic.
module mult_booth_seq (
  input  logic             clock,
  input  logic             reset_n,
  mult_booth_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [33:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        q_q, q_d;
  logic [33:0] acand_q, acand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;

  logic [33:0] mag;
  logic        neg;
  logic [33:0] add_b;
  logic [33:0] sum;

  // Booth recode of {lo[1:0], q} into magnitude and sign
  always_comb begin
    mag = '0;
    neg = 1'b0;
    unique case ({lo_q[1:0], q_q})
      3'b000: mag = '0;
      3'b001: mag = acand_q;
      3'b010: mag = acand_q;
      3'b011: mag = {acand_q[32:0], 1'b0};
      3'b100: begin
        mag = {acand_q[32:0], 1'b0};
        neg = 1'b1;
      end
      3'b101: begin
        mag = acand_q;
        neg = 1'b1;
      end
      3'b110: begin
        mag = acand_q;
        neg = 1'b1;
      end
      3'b111: mag = '0;
      default: mag = '0;
    endcase
  end

  // 34-bit adder; negation is invert plus carry-in
  always_comb begin
    add_b = neg ? ~mag : mag;
    sum   = hi_q + add_b + {33'd0, neg};
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    q_d     = q_q;
    acand_d = acand_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          hi_d    = '0;
          lo_d    = bus.multiplier;
          q_d     = 1'b0;
          acand_d = {{2{bus.multiplicand[31]}},
                     bus.multiplicand};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        hi_d  = {{2{sum[33]}}, sum[33:2]};
        lo_d  = {sum[1:0], lo_q[31:2]};
        q_d   = lo_q[1];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        res_d   = lo_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      q_q     <= 1'b0;
      acand_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      q_q     <= q_d;
      acand_q <= acand_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

`ifdef MULT_OVF_EN
  logic exc_q, exc_d;
  logic ovf;

  // Product overflows when the high word is not a sign copy of lo
  always_comb begin
    ovf   = (hi_q[31:0] != {32{lo_q[31]}});
    exc_d = exc_q;
    if (state_q == DONE) exc_d = ovf;
  end

  // Exception register, updated with the result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) exc_q <= 1'b0;
    else          exc_q <= exc_d;
  end

  assign bus.exception = exc_q;
`else
  assign bus.exception = 1'b0;
`endif

  assign bus.busy        = (state_q != IDLE);
  assign bus.resultReady = (state_q == DONE);
  assign bus.result      = res_q;

endmodule
